// File: rtl/mips_regfile_if.sv
// Register-file bus: IR fields, writeback strobes/data, A/B operands and debug read.
// master = control/datapath side driving strobes, slave = the register file.
interface mips_regfile_if #(
    parameter int N = 32
);
    logic [31:0]  instr;
    logic         RegWrite;
    logic         RegDst;
    logic         MemtoReg;
    logic [N-1:0] alu_out;
    logic [N-1:0] mdr;
    logic [N-1:0] reg_a;
    logic [N-1:0] reg_b;
    logic [4:0]   dbg_addr;
    logic [N-1:0] dbg_data;

    modport master (
        output instr, RegWrite, RegDst, MemtoReg,
        output alu_out, mdr, dbg_addr,
        input  reg_a, reg_b, dbg_data
    );

    modport slave (
        input  instr, RegWrite, RegDst, MemtoReg,
        input  alu_out, mdr, dbg_addr,
        output reg_a, reg_b, dbg_data
    );
endinterface

// File: rtl/mips_regfile.sv
// Multi-cycle MIPS register file: 32 x N GPRs (r0 = 0), A/B operand latches,
// writeback under RegWrite/RegDst/MemtoReg, combinational debug read port.
// Ports: clk, rst (sync, active-high), bus (mips_regfile_if.slave).
// Option: MIPS_REGFILE_BYPASS_EN forwards same-edge write data into A/B.
module mips_regfile #(
    parameter int N = 32
) (
    input logic           clk,
    input logic           rst,
    mips_regfile_if.slave bus
);
    logic [N-1:0] regs [32];

    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   waddr;
    logic [N-1:0] wdata;
    logic         we;
    logic [N-1:0] rd_a;
    logic [N-1:0] rd_b;
    logic [N-1:0] nxt_a;
    logic [N-1:0] nxt_b;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         unused_instr;

    assign rs    = bus.instr[25:21];
    assign rt    = bus.instr[20:16];
    assign waddr = bus.RegDst ? bus.instr[15:11] : bus.instr[20:16];
    assign wdata = bus.MemtoReg ? bus.mdr : bus.alu_out;

    // Writes to r0 are dropped here so r0 never leaves its reset value.
    assign we = bus.RegWrite && (waddr != 5'd0);

    assign rd_a = (rs == 5'd0) ? '0 : regs[rs];
    assign rd_b = (rt == 5'd0) ? '0 : regs[rt];

`ifdef MIPS_REGFILE_BYPASS_EN
    assign nxt_a = (we && waddr == rs) ? wdata : rd_a;
    assign nxt_b = (we && waddr == rt) ? wdata : rd_b;
`else
    // A/B take the pre-write array value; new data shows one edge later.
    assign nxt_a = rd_a;
    assign nxt_b = rd_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (we) begin
                regs[waddr] <= wdata;
            end
            a_q <= nxt_a;
            b_q <= nxt_b;
        end
    end

    assign bus.reg_a    = a_q;
    assign bus.reg_b    = b_q;
    assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? '0 : regs[bus.dbg_addr];

    assign unused_instr = ^{bus.instr[31:26], bus.instr[10:0]};
endmodule

// File: tb/tb_mips_regfile.sv
// Bench for mips_regfile: directed test-plan cases plus randomized traffic
// checked every cycle against an array-based register model.
module tb_mips_regfile;
    localparam int N = 32;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    mips_regfile_if #(.N(N)) bus ();

    mips_regfile #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m [32];
    logic [31:0] ma;
    logic [31:0] mb;

    function automatic logic [31:0] mread(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : m[i];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ins);
        return ins[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ins);
        return ins[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ins);
        return ins[15:11];
    endfunction

    function automatic logic [4:0] dest();
        return bus.RegDst ? f_rd(bus.instr) : f_rt(bus.instr);
    endfunction

    function automatic logic [31:0] wval();
        return bus.MemtoReg ? bus.mdr : bus.alu_out;
    endfunction

    // Operand seen on this edge: forwarded write data only in bypass build.
    function automatic logic [31:0] operand(input logic [4:0] src);
        logic hit;
        hit = bus.RegWrite && (dest() != 5'd0) && (dest() == src);
`ifdef MIPS_REGFILE_BYPASS_EN
        if (hit) return wval();
`else
        if (hit) return mread(src);
`endif
        return mread(src);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m[i] <= 32'd0;
            ma <= 32'd0;
            mb <= 32'd0;
        end else begin
            ma <= operand(f_rs(bus.instr));
            mb <= operand(f_rt(bus.instr));
            if (bus.RegWrite && dest() != 5'd0) m[dest()] <= wval();
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_reg_a", bus.reg_a, ma);
            chk("model_reg_b", bus.reg_b, mb);
            chk("model_dbg", bus.dbg_data, mread(bus.dbg_addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] s,
                                       input logic [4:0] t,
                                       input logic [4:0] d);
        return {6'd0, s, t, d, 11'd0};
    endfunction

    task automatic idle();
        bus.RegWrite = 1'b0;
        bus.instr    = 32'd0;
    endtask

    task automatic wr_rd(input logic [4:0] d, input logic [31:0] v);
        bus.instr    = mk(5'd0, 5'd0, d);
        bus.RegDst   = 1'b1;
        bus.MemtoReg = 1'b0;
        bus.alu_out  = v;
        bus.RegWrite = 1'b1;
        step();
        idle();
    endtask

    task automatic dbg(input string name, input logic [4:0] a,
                       input logic [31:0] exp);
        bus.dbg_addr = a;
        #1;
        chk(name, bus.dbg_data, exp);
    endtask

    initial begin
        logic [31:0] exp_a;
        rst          = 1'b1;
        bus.instr    = 32'd0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.alu_out  = 32'd0;
        bus.mdr      = 32'd0;
        bus.dbg_addr = 5'd0;
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset clears a preloaded register; RegWrite during reset ignored.
        wr_rd(5'd5, 32'h1234);
        dbg("preload_r5", 5'd5, 32'h1234);
        rst          = 1'b1;
        bus.instr    = mk(5'd5, 5'd5, 5'd5);
        bus.RegDst   = 1'b1;
        bus.alu_out  = 32'h9999;
        bus.RegWrite = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk("rst_reg_a", bus.reg_a, 32'd0);
        chk("rst_reg_b", bus.reg_b, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg("rst_dbg", 5'(i), 32'd0);
            step();
        end

        // R-type writeback to rd=3, rt=2 untouched.
        bus.instr    = mk(5'd1, 5'd2, 5'd3);
        bus.RegDst   = 1'b1;
        bus.MemtoReg = 1'b0;
        bus.alu_out  = 32'hDEADBEEF;
        bus.mdr      = 32'h0BAD0BAD;
        bus.RegWrite = 1'b1;
        step();
        idle();
        dbg("rtype_r3", 5'd3, 32'hDEADBEEF);
        dbg("rtype_r2", 5'd2, 32'd0);

        // Load writeback to rt=7 from mdr.
        bus.instr    = mk(5'd1, 5'd7, 5'd9);
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b1;
        bus.mdr      = 32'h000000FF;
        bus.alu_out  = 32'h55555555;
        bus.RegWrite = 1'b1;
        step();
        idle();
        dbg("load_r7", 5'd7, 32'h000000FF);
        dbg("load_r9", 5'd9, 32'd0);

        // r0 stays zero.
        wr_rd(5'd0, 32'hFFFFFFFF);
        dbg("r0_dbg", 5'd0, 32'd0);
        bus.instr = mk(5'd0, 5'd0, 5'd0);
        step();
        chk("r0_reg_a", bus.reg_a, 32'd0);
        chk("r0_reg_b", bus.reg_b, 32'd0);

        // Operand latch.
        wr_rd(5'd4, 32'h11);
        wr_rd(5'd9, 32'h22);
        bus.instr = mk(5'd4, 5'd9, 5'd0);
        step();
        chk("latch_reg_a", bus.reg_a, 32'h11);
        chk("latch_reg_b", bus.reg_b, 32'h22);

        // Same-edge write/read hazard on r6.
        wr_rd(5'd6, 32'h5);
        bus.instr    = mk(5'd6, 5'd0, 5'd6);
        bus.RegDst   = 1'b1;
        bus.MemtoReg = 1'b0;
        bus.alu_out  = 32'hA;
        bus.RegWrite = 1'b1;
        step();
        bus.RegWrite = 1'b0;
`ifdef MIPS_REGFILE_BYPASS_EN
        exp_a = 32'hA;
`else
        exp_a = 32'h5;
`endif
        chk("hazard_edge", bus.reg_a, exp_a);
        step();
        chk("hazard_next", bus.reg_a, 32'hA);
        idle();

        // Randomized traffic; small register pool to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.instr = {$urandom_range(0, 63) == 0 ? $urandom() :
                         {6'd0, 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 11'($urandom())}};
            bus.RegWrite = $urandom_range(0, 1) == 1;
            bus.RegDst   = $urandom_range(0, 1) == 1;
            bus.MemtoReg = $urandom_range(0, 1) == 1;
            bus.alu_out  = $urandom();
            bus.mdr      = $urandom();
            bus.dbg_addr = 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
